// File: rtl/mem_dump_reader_if.sv
// mem_dump_reader_if: memory read port and output word stream of the dump reader
interface mem_dump_reader_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    modport master (
        output mem_rd_en, mem_addr, out_valid, out_data, out_addr,
        input  mem_rd_data, out_ready
    );
    modport slave (
        input  mem_rd_en, mem_addr, out_valid, out_data, out_addr,
        output mem_rd_data, out_ready
    );
endinterface

// File: rtl/mem_dump_reader.sv
// mem_dump_reader: after HALTED, streams a memory window out and checks it is non-decreasing
module mem_dump_reader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int BASE   = 100,
    parameter int COUNT  = 20
) (
    input  logic                clk1,
    input  logic                rst,
    input  logic                halted,
    mem_dump_reader_if.master   bus,
    output logic                done,
    output logic                sorted_ok,
    output logic [ADDR_W-1:0]   err_addr
);
    localparam int IDX_W = $clog2(COUNT) + 1;
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(COUNT - 1);

    typedef enum logic [2:0] {IDLE, RD, WT, PRES, DONE} state_t;

    state_t state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] prev_q, prev_d, out_data_q, out_data_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d, out_addr_q, out_addr_d, err_addr_q, err_addr_d;
    logic sorted_ok_q, sorted_ok_d;

    // Next-state: one read, one capture, then hold the word until the sink takes it
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        prev_d      = prev_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        mem_addr_d  = mem_addr_q;
        sorted_ok_d = sorted_ok_q;
        err_addr_d  = err_addr_q;
        case (state_q)
            IDLE: if (halted) begin
                state_d    = RD;
                mem_addr_d = BASE_A;
            end
            RD: state_d = WT;
            WT: begin
                out_data_d = bus.mem_rd_data;
                out_addr_d = mem_addr_q;
                state_d    = PRES;
            end
            PRES: if (bus.out_ready) begin
                if (idx_q != '0 && sorted_ok_q && out_data_q < prev_q) begin
                    sorted_ok_d = 1'b0;
                    err_addr_d  = out_addr_q;
                end
                prev_d = out_data_q;
                if (idx_q == LAST) begin
                    state_d = DONE;
                end else begin
                    idx_d      = idx_q + IDX_W'(1);
                    mem_addr_d = BASE_A + ADDR_W'(idx_q + IDX_W'(1));
                    state_d    = RD;
                end
            end
            DONE: ;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any partial scan
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            prev_q      <= '0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            mem_addr_q  <= BASE_A;
            sorted_ok_q <= 1'b1;
            err_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            prev_q      <= prev_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            mem_addr_q  <= mem_addr_d;
            sorted_ok_q <= sorted_ok_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign bus.mem_rd_en = state_q == RD;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.out_valid = state_q == PRES;
    assign bus.out_data  = out_data_q;
    assign bus.out_addr  = out_addr_q;
    assign done          = state_q == DONE;
    assign sorted_ok     = sorted_ok_q;
    assign err_addr      = err_addr_q;
endmodule

// File: tb/tb_mem_dump_reader.sv
// tb_mem_dump_reader: scoreboard bench for the memory dump reader
module tb_mem_dump_reader;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BASE = 100;
    localparam int COUNT = 20;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } beat_t;

    logic clk1 = 1'b0;
    logic rst = 1'b1;
    logic halted = 1'b0;
    logic done, sorted_ok;
    logic [AW-1:0] err_addr;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    int errors = 0;
    int checks = 0;
    int acc_cnt = 0;
    beat_t q[$];
    logic mon_stall = 1'b0;
    logic [AW-1:0] mon_sa;
    logic [DW-1:0] mon_sd;

    mem_dump_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_dump_reader #(.ADDR_W(AW), .DATA_W(DW), .BASE(BASE), .COUNT(COUNT)) dut (
        .clk1      (clk1),
        .rst       (rst),
        .halted    (halted),
        .bus       (bus.master),
        .done      (done),
        .sorted_ok (sorted_ok),
        .err_addr  (err_addr)
    );

    always #5 clk1 = ~clk1;

    // Single-port memory with one cycle of read latency
    always @(posedge clk1) if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each accepted beat and checks stall stability
    initial forever begin
        @(negedge clk1);
        if (rst) begin
            mon_stall = 1'b0;
        end else begin
            if (bus.mem_rd_en && q.size() > 0) chk("read address", bus.mem_addr, q[0].a);
            if (mon_stall) begin
                chk("stall valid held", bus.out_valid, 1);
                chk("stall data held", bus.out_data, mon_sd);
                chk("stall addr held", bus.out_addr, mon_sa);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("beat with empty scoreboard", q.size(), 1);
                end else begin
                    beat_t e;
                    e = q.pop_front();
                    chk("beat addr", bus.out_addr, e.a);
                    chk("beat data", bus.out_data, e.d);
                end
                acc_cnt++;
                mon_stall = 1'b0;
            end else if (bus.out_valid) begin
                mon_stall = 1'b1;
                mon_sa = bus.out_addr;
                mon_sd = bus.out_data;
            end else begin
                mon_stall = 1'b0;
            end
        end
    end

    task automatic check_reset();
        chk("rst mem_rd_en", bus.mem_rd_en, 0);
        chk("rst mem_addr", bus.mem_addr, BASE);
        chk("rst out_valid", bus.out_valid, 0);
        chk("rst out_data", bus.out_data, 0);
        chk("rst out_addr", bus.out_addr, 0);
        chk("rst done", done, 0);
        chk("rst sorted_ok", sorted_ok, 1);
        chk("rst err_addr", err_addr, 0);
    endtask

    // Called just after a rising edge; asserts reset, checks it took effect at once, releases
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_reset();
        q.delete();
        @(posedge clk1);
        #1;
        check_reset();
        rst = 1'b0;
    endtask

    task automatic push_window();
        beat_t b;
        for (int i = 0; i < COUNT; i++) begin
            b.a = AW'(BASE + i);
            b.d = mem[BASE + i];
            q.push_back(b);
        end
    endtask

    // Reference: first word smaller (unsigned) than its predecessor
    task automatic model_sorted(output logic ok, output logic [AW-1:0] ea);
        ok = 1'b1;
        ea = '0;
        for (int i = 1; i < COUNT; i++)
            if (ok && mem[BASE + i] < mem[BASE + i - 1]) begin
                ok = 1'b0;
                ea = AW'(BASE + i);
            end
    endtask

    task automatic run_to_done(input int mode, input bit drop, output int first_rd, output int done_cyc);
        logic ok;
        logic [AW-1:0] ea;
        first_rd = -1;
        done_cyc = -1;
        for (int c = 1; c <= 3000; c++) begin
            @(posedge clk1);
            #1;
            if (first_rd < 0 && bus.mem_rd_en) first_rd = c;
            if (done) begin
                done_cyc = c;
                break;
            end
            if (drop && c == 3) halted = 1'b0;
            bus.out_ready = mode == 0 ? 1'b1 : mode == 1 ? ~bus.out_ready : 1'($urandom_range(0, 1));
        end
        chk("done reached", done_cyc > 0, 1);
        model_sorted(ok, ea);
        chk("sorted_ok", sorted_ok, ok);
        chk("err_addr", err_addr, ea);
        chk("beats outstanding", q.size(), 0);
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk1);
        #1;
        chk("done sticky", done, 1);
        chk("idle after done", {bus.out_valid, bus.mem_rd_en}, 0);
    endtask

    initial begin
        int fr, dc, base_acc;
        bit bad, seen;
        logic [DW-1:0] v;
        bus.out_ready = 1'b1;
        halted = 1'b1;
        @(posedge clk1);
        #1;

        // Ascending window, halted high out of reset
        for (int i = 0; i < COUNT; i++) mem[BASE + i] = DW'(i + 1);
        do_reset();
        push_window();
        run_to_done(0, 0, fr, dc);
        chk("cycles first read to done", dc - fr, 3 * COUNT);

        // Descending window
        for (int i = 0; i < COUNT; i++) mem[BASE + i] = DW'(COUNT - i);
        do_reset();
        push_window();
        run_to_done(0, 0, fr, dc);
        chk("descending err_addr", err_addr, BASE + 1);

        // Ascending with out_ready toggling
        for (int i = 0; i < COUNT; i++) mem[BASE + i] = DW'(i + 1);
        do_reset();
        push_window();
        run_to_done(1, 0, fr, dc);

        // Halted low for 50 cycles
        halted = 1'b0;
        do_reset();
        bad = 1'b0;
        repeat (50) begin
            @(posedge clk1);
            #1;
            if (bus.mem_rd_en || bus.out_valid) bad = 1'b1;
        end
        chk("quiet while not halted", bad, 0);
        push_window();
        halted = 1'b1;
        @(posedge clk1);
        #1;
        chk("start read strobe", bus.mem_rd_en, 1);
        chk("start read addr", bus.mem_addr, BASE);
        run_to_done(0, 0, fr, dc);

        // Reset after the 7th accept, then rescan from the start
        do_reset();
        push_window();
        base_acc = acc_cnt;
        seen = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(posedge clk1);
            #1;
            if (acc_cnt == base_acc + 7) begin
                seen = 1'b1;
                break;
            end
        end
        chk("seven accepts seen", seen, 1);
        do_reset();
        push_window();
        run_to_done(0, 0, fr, dc);

        // Equal adjacent words count as sorted
        for (int i = 0; i < COUNT; i++) mem[BASE + i] = i < 4 ? DW'(i + 1) : i < 6 ? DW'(7) : DW'(i + 2);
        do_reset();
        push_window();
        run_to_done(0, 0, fr, dc);
        chk("equal words sorted", sorted_ok, 1);

        // Randomized windows, random back-pressure, halted sometimes dropped mid-scan
        for (int k = 0; k < 6; k++) begin
            v = $urandom_range(0, 100);
            for (int i = 0; i < COUNT; i++) begin
                v = v + DW'($urandom_range(0, 2));
                mem[BASE + i] = k % 3 == 0 ? v : k % 3 == 1 ? DW'($urandom_range(0, 15)) : $urandom();
            end
            halted = 1'b1;
            do_reset();
            push_window();
            run_to_done(2, k[0], fr, dc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
